color_cmd_ctrl: RTL and testbench

Frame parser and sequencer between the UART receiver and the three PWM channels of the color mixer. Collects a 5-byte command frame from the receiver's byte stream, checks it, and loads the red/green/blue duty registers in a single cycle. Malformed or stalled frames are discarded and flagged. The PWM generators read only the registered duty outputs of this block.

---
 rtl/color_mixer_pkg.sv | 31 +++
 rtl/color_cmd_ctrl_frame_timer.sv | 42 ++++
 rtl/color_cmd_ctrl.sv | 159 +++++++++++++++
 tb/tb_color_cmd_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/color_mixer_pkg.sv
// Shared types and defaults for the color mixer command path and PWM channels.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package color_mixer_pkg;

    // Duty register width, shared with the PWM generators.
    localparam int DUTY_W = 8;

    // Start-of-frame marker.
    localparam logic [7:0] HEADER_DEF = 8'hAA;

    // Max idle clocks between bytes inside a frame: 3 byte times at 1200 baud, 10 MHz clock.
    localparam int TIMEOUT_CYCLES_DEF = 250000;

    // Frame parser states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_R,
        ST_GET_G,
        ST_GET_B,
        ST_GET_CHK
    } state_t;

    // Expected checksum byte for a color triple.
    function automatic logic [7:0] frame_chk(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return r ^ g ^ b;
    endfunction

endpackage

// File: rtl/color_cmd_ctrl_frame_timer.sv
// Inter-byte idle timer: counts enabled cycles and flags expiry at LIMIT-1.
// Latency: expire_o is combinational from the registered count.
// Backpressure: none; clr_i always wins over counting and suppresses expiry.
module frame_timer #(
    parameter int LIMIT = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on demand, otherwise count while enabled and park at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A byte arriving in the last cycle clears the timer, so it beats expiry.
    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/color_cmd_ctrl.sv
// UART command frame parser: HEADER,R,G,B,CHK -> atomic load of the three duty registers.
// Latency: duties/update (or frame_err) register on the edge that samples the CHK byte.
// Backpressure: none; rx_valid is a strobe, every strobe is consumed, stalls abort via timeout.
module color_cmd_ctrl
    import color_mixer_pkg::*;
#(
    parameter logic [7:0] HEADER         = HEADER_DEF,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [DUTY_W-1:0] red_duty,
    output logic [DUTY_W-1:0] green_duty,
    output logic [DUTY_W-1:0] blue_duty,
    output logic              update,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [7:0]        shd_r_q, shd_r_d;
    logic [7:0]        shd_g_q, shd_g_d;
    logic [7:0]        shd_b_q, shd_b_d;
    logic [DUTY_W-1:0] red_q, red_d;
    logic [DUTY_W-1:0] green_q, green_d;
    logic [DUTY_W-1:0] blue_q, blue_d;
    logic              update_q, update_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expire;
    logic drop;

    // Timer restarts on the accepted HEADER and on every in-frame byte; runs while busy.
    assign tmr_en  = (state_q != ST_IDLE);
    assign tmr_clr = rx_valid && ((state_q != ST_IDLE) || (rx_data == HEADER));

    frame_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk      (clk),
        .rst      (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    // Next-state and register updates; commit and error pulses default low.
    always_comb begin
        state_d   = state_q;
        shd_r_d   = shd_r_q;
        shd_g_d   = shd_g_q;
        shd_b_d   = shd_b_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        update_d  = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        drop      = tmr_expire;

        case (state_q)
            ST_IDLE: begin
                // Non-header bytes between frames are line noise, not errors.
                if (rx_valid && (rx_data == HEADER)) begin
                    state_d = ST_GET_R;
                end
            end
            ST_GET_R: begin
                // HEADER value is plain data once inside a frame.
                if (rx_valid) begin
                    shd_r_d = rx_data;
                    state_d = ST_GET_G;
                end
            end
            ST_GET_G: begin
                if (rx_valid) begin
                    shd_g_d = rx_data;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (rx_valid) begin
                    shd_b_d = rx_data;
                    state_d = ST_GET_CHK;
                end
            end
            ST_GET_CHK: begin
                if (rx_valid) begin
                    if (rx_data == frame_chk(shd_r_q, shd_g_q, shd_b_q)) begin
                        red_d    = DUTY_W'(shd_r_q);
                        green_d  = DUTY_W'(shd_g_q);
                        blue_d   = DUTY_W'(shd_b_q);
                        update_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Checksum failure or stall: discard the partial frame and count it.
        if (drop) begin
            state_d = ST_IDLE;
            shd_r_d = '0;
            shd_g_d = '0;
            shd_b_d = '0;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // State, shadow and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shd_r_q   <= '0;
            shd_g_q   <= '0;
            shd_b_q   <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shd_r_q   <= shd_r_d;
            shd_g_q   <= shd_g_d;
            shd_b_q   <= shd_b_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            update_q  <= update_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign red_duty   = red_q;
    assign green_duty = green_q;
    assign blue_duty  = blue_q;
    assign update     = update_q;
    assign frame_err  = err_q;
    assign err_count  = err_cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_color_cmd_ctrl.sv
// Directed bench for color_cmd_ctrl: frame table plus timeout, noise, saturation and reset sequences.
// Latency: checks sample 1 ns after the clock edge that consumes each byte.
// Backpressure: n/a; bytes are driven as single-cycle strobes.
module tb_color_cmd_ctrl;

    localparam int T = 20;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] red_duty;
    logic [7:0] green_duty;
    logic [7:0] blue_duty;
    logic       update;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    int checks;
    int failures;

    color_cmd_ctrl #(
        .HEADER         (8'hAA),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .red_duty   (red_duty),
        .green_duty (green_duty),
        .blue_duty  (blue_duty),
        .update     (update),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] exp_r;
        logic [7:0] exp_g;
        logic [7:0] exp_b;
        logic       exp_upd;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] stream[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One byte as a single-cycle strobe; returns 1 ns after the consuming edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic [7:0] c);
        send_byte(8'hAA);
        send_byte(r);
        send_byte(g);
        send_byte(b);
        send_byte(c);
    endtask

    initial begin
        int seen;
        checks   = 0;
        failures = 0;

        //                 R      G      B      CHK    expR   expG   expB   upd   err   cnt
        vecs[0] = '{8'h10, 8'h20, 8'h30, 8'h00, 8'h10, 8'h20, 8'h30, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h80, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{8'hFF, 8'h00, 8'h80, 8'h7E, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b1, 8'd1};
        vecs[3] = '{8'h01, 8'h02, 8'h04, 8'h07, 8'h01, 8'h02, 8'h04, 1'b1, 1'b0, 8'd1};
        vecs[4] = '{8'hAA, 8'h55, 8'h00, 8'hFF, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 8'd1};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1, 8'd2};

        stream[0] = 8'hAA; stream[1] = 8'h01; stream[2] = 8'h02; stream[3] = 8'h03; stream[4] = 8'h00;
        stream[5] = 8'hAA; stream[6] = 8'h04; stream[7] = 8'h05; stream[8] = 8'h06; stream[9] = 8'h07;

        // Reset state, checked while reset is held.
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        chk("rst_red", red_duty, 8'h00);
        chk("rst_green", green_duty, 8'h00);
        chk("rst_blue", blue_duty, 8'h00);
        chk("rst_update", update, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Frame table.
        for (int i = 0; i < 6; i++) begin
            send_byte(8'hAA);
            chk($sformatf("v%0d_busy_hdr", i), busy, 1'b1);
            send_byte(vecs[i].r);
            send_byte(vecs[i].g);
            send_byte(vecs[i].b);
            send_byte(vecs[i].c);
            chk($sformatf("v%0d_update", i), update, vecs[i].exp_upd);
            chk($sformatf("v%0d_frame_err", i), frame_err, vecs[i].exp_err);
            chk($sformatf("v%0d_red", i), red_duty, vecs[i].exp_r);
            chk($sformatf("v%0d_green", i), green_duty, vecs[i].exp_g);
            chk($sformatf("v%0d_blue", i), blue_duty, vecs[i].exp_b);
            chk($sformatf("v%0d_err_count", i), err_count, vecs[i].exp_cnt);
            chk($sformatf("v%0d_busy_end", i), busy, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_update_1cyc", i), update, 1'b0);
            chk($sformatf("v%0d_err_1cyc", i), frame_err, 1'b0);
        end

        // Stall after AA 11 22: error exactly T cycles after the last byte.
        send_byte(8'hAA);
        send_byte(8'h11);
        send_byte(8'h22);
        seen = 0;
        for (int k = 1; k <= T + 5; k++) begin
            @(posedge clk);
            #1;
            if (frame_err && seen == 0) seen = k;
        end
        chk("stall_expiry_cycle", seen, T);
        chk("stall_err_count", err_count, 8'd3);
        chk("stall_busy", busy, 1'b0);
        chk("stall_red_kept", red_duty, 8'hAA);
        send_frame(8'h01, 8'h02, 8'h04, 8'h07);
        chk("post_stall_update", update, 1'b1);
        chk("post_stall_red", red_duty, 8'h01);
        chk("post_stall_green", green_duty, 8'h02);
        chk("post_stall_blue", blue_duty, 8'h04);

        // Byte landing on the exact expiry cycle is accepted.
        send_byte(8'hAA);
        send_byte(8'h11);
        repeat (T - 1) @(posedge clk);
        #1;
        chk("bound_busy_before", busy, 1'b1);
        chk("bound_no_err_before", frame_err, 1'b0);
        rx_data  = 8'h22;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("bound_no_err", frame_err, 1'b0);
        chk("bound_busy", busy, 1'b1);
        chk("bound_err_count", err_count, 8'd3);
        send_byte(8'h33);
        send_byte(8'h00);
        chk("bound_update", update, 1'b1);
        chk("bound_red", red_duty, 8'h11);
        chk("bound_green", green_duty, 8'h22);
        chk("bound_blue", blue_duty, 8'h33);

        // Noise in IDLE, then HEADER treated as R data.
        send_byte(8'h55);
        chk("noise55_busy", busy, 1'b0);
        send_byte(8'h00);
        chk("noise00_busy", busy, 1'b0);
        chk("noise_no_err", frame_err, 1'b0);
        send_byte(8'hAA);
        chk("noise_hdr_busy", busy, 1'b1);
        send_byte(8'hAA);
        chk("noise_aa_as_data_busy", busy, 1'b1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("noise_frame_err", frame_err, 1'b1);
        chk("noise_err_count", err_count, 8'd4);
        chk("noise_red_kept", red_duty, 8'h11);

        // Saturation after 300 further failures.
        for (int n = 0; n < 300; n++) begin
            send_frame(8'h00, 8'h00, 8'h00, 8'h01);
        end
        chk("sat_frame_err", frame_err, 1'b1);
        chk("sat_err_count", err_count, 8'd255);
        chk("sat_blue_kept", blue_duty, 8'h33);

        // Back-to-back frames on consecutive strobes.
        @(posedge clk);
        #1;
        rx_data  = stream[0];
        rx_valid = 1'b1;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                chk("b2b_first_update", update, 1'b1);
                chk("b2b_first_red", red_duty, 8'h01);
                chk("b2b_first_blue", blue_duty, 8'h03);
            end
            rx_data = stream[i];
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("b2b_second_update", update, 1'b1);
        chk("b2b_second_red", red_duty, 8'h04);
        chk("b2b_second_green", green_duty, 8'h05);
        chk("b2b_second_blue", blue_duty, 8'h06);
        chk("b2b_err_count", err_count, 8'd255);

        // Reset asserted in GET_G clears everything asynchronously.
        send_byte(8'hAA);
        send_byte(8'h05);
        chk("midrst_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_red", red_duty, 8'h00);
        chk("midrst_green", green_duty, 8'h00);
        chk("midrst_blue", blue_duty, 8'h00);
        chk("midrst_err_count", err_count, 8'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_frame(8'h10, 8'h20, 8'h30, 8'h00);
        chk("postrst_update", update, 1'b1);
        chk("postrst_red", red_duty, 8'h10);
        chk("postrst_green", green_duty, 8'h20);
        chk("postrst_blue", blue_duty, 8'h30);
        chk("postrst_err_count", err_count, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
